// File: rtl/layer7_weight_dump_if.sv
// ---------------------------------------------------------------------------
// layer7_weight_dump_if
//
// Stream port of the layer-7 weight dump. The producer (dump block) drives
// the word, its position tags and valid. The consumer drives ready.
//
//   dump_data    word being offered
//   dump_valid   dump_data is valid
//   dump_ready   consumer accepts the word at the next rising edge
//   dump_last    current word is the final word of the dump
//   dump_neuron  neuron index of the current word (7 = checksum word)
//   dump_index   word index within the neuron (0..N+1)
//
// Modports: master = dump block, slave = consumer.
// ---------------------------------------------------------------------------
interface layer7_weight_dump_if #(
  parameter int N      = 16,
  parameter int FRAC_W = 16
);
  localparam int IDX_W = $clog2(N + 2);

  logic [FRAC_W-1:0] dump_data;
  logic              dump_valid;
  logic              dump_ready;
  logic              dump_last;
  logic [2:0]        dump_neuron;
  logic [IDX_W-1:0]  dump_index;

  modport master (
    output dump_data, dump_valid, dump_last, dump_neuron, dump_index,
    input  dump_ready
  );

  modport slave (
    input  dump_data, dump_valid, dump_last, dump_neuron, dump_index,
    output dump_ready
  );
endinterface

// File: rtl/layer7_weight_dump.sv
// ---------------------------------------------------------------------------
// layer7_weight_dump
//
// On start, snapshots the weights, activation_max and activation_min of the
// seven-neuron layer into a shadow register and streams the snapshot out one
// word per valid/ready handshake. The live inputs may keep changing while
// the stream drains; only the snapshot is ever sent.
//
// Word order per neuron j (j = 0..6):
//   index 0..N-1 : weights[j][0..N-1]
//   index N      : activation_max[j]
//   index N+1    : activation_min[j]
//
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   start            request a dump (accepted in IDLE and in DONE)
//   abort            cancel the dump in progress (STREAM only)
//   weights          live layer weights, [7][N]
//   activation_max   live layer activation maxima, [7]
//   activation_min   live layer activation minima, [7]
//   stream           master side of layer7_weight_dump_if
//   busy             dump in progress (STREAM or DONE)
//   done             one-cycle pulse after the final handshake
//
// Build option DUMP_CHECKSUM_EN: appends one word after the last payload
// word, holding the modulo-2^FRAC_W sum of all payload words, tagged with
// neuron 7 / index 0 and carrying dump_last. Undefined by default.
//
// Every output comes straight from a flop or from a decode of the state
// register; dump_ready only steers next-state logic.
// ---------------------------------------------------------------------------
module layer7_weight_dump #(
  parameter int N      = 16,
  parameter int FRAC_W = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [FRAC_W-1:0]   weights        [7][N],
  input  logic [FRAC_W-1:0]   activation_max [7],
  input  logic [FRAC_W-1:0]   activation_min [7],
  layer7_weight_dump_if.master stream,
  output logic                busy,
  output logic                done
);

  localparam int NEURONS  = 7;
  localparam int IDX_W    = $clog2(N + 2);
  localparam int PAYLOAD  = NEURONS * (N + 2);
  localparam int PTR_W    = $clog2(PAYLOAD);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(PAYLOAD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N + 1);

`ifdef DUMP_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef logic [FRAC_W-1:0] frac_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  frac_t [PAYLOAD-1:0]    live_flat;
  frac_t [PAYLOAD-1:0]    shadow;
  logic  [PTR_W-1:0]      ptr_q;
  logic  [PTR_W-1:0]      ptr_nxt;
  logic  [2:0]            neuron_q;
  logic  [IDX_W-1:0]      index_q;
  frac_t                  data_q;
  logic                   last_q;
  logic                   accept_start;
  logic                   handshake;
  logic                   final_word;

  // Live inputs laid out in stream order, so the snapshot is a single
  // vector indexed by one linear word pointer.
  for (genvar j = 0; j < NEURONS; j++) begin : g_neuron
    for (genvar i = 0; i < N; i++) begin : g_weight
      assign live_flat[j*(N+2) + i] = weights[j][i];
    end
    assign live_flat[j*(N+2) + N]     = activation_max[j];
    assign live_flat[j*(N+2) + N + 1] = activation_min[j];
  end

  // DONE behaves like IDLE for start, giving back-to-back dumps.
  assign accept_start = start && (state_q == IDLE || state_q == DONE);
  // Abort wins over a simultaneous handshake: that word is not delivered.
  assign handshake    = (state_q == STREAM) && stream.dump_ready && !abort;
  assign ptr_nxt      = ptr_q + PTR_W'(1);

`ifdef DUMP_CHECKSUM_EN
  frac_t sum_q;
  logic  on_ck;

  assign final_word = on_ck;

  // Running sum of delivered payload words; on_ck marks that the checksum
  // word is the one currently offered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      on_ck <= 1'b0;
    end else if (accept_start) begin
      sum_q <= '0;
      on_ck <= 1'b0;
    end else if (handshake && !on_ck) begin
      sum_q <= sum_q + data_q;
      if (ptr_q == LAST_PTR) on_ck <= 1'b1;
    end
  end
`else
  assign final_word = (ptr_q == LAST_PTR);
`endif

  // --- FSM ------------------------------------------------------------------
  // NOTE: state and every other flop use non-blocking assignments; the
  // combinational next-state block assigns its default first so no path
  // leaves state_d unassigned and no latch is inferred.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM: begin
        if (abort)                         state_d = IDLE;
        else if (handshake && final_word)  state_d = DONE;
      end
      DONE:    state_d = start ? STREAM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --- Snapshot and word pointer ---------------------------------------------
  // dump_data is registered: on each handshake the next word is fetched from
  // the shadow into data_q, so the offered word holds while ready is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the shadow is cleared on reset like ordinary state, so no stale
      // snapshot survives a reset; a buffer whose contents can never reach an
      // output before being written would normally be left unreset.
      shadow   <= '0;
      ptr_q    <= '0;
      neuron_q <= '0;
      index_q  <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else if (accept_start) begin
      shadow   <= live_flat;
      ptr_q    <= '0;
      neuron_q <= '0;
      index_q  <= '0;
      data_q   <= live_flat[0];
      last_q   <= 1'b0;
    end else if (handshake && !final_word) begin
`ifdef DUMP_CHECKSUM_EN
      if (ptr_q == LAST_PTR) begin
        data_q   <= sum_q + data_q;
        neuron_q <= 3'd7;
        index_q  <= '0;
        last_q   <= 1'b1;
      end else
`endif
      begin
        ptr_q  <= ptr_nxt;
        data_q <= shadow[ptr_nxt];
        last_q <= !CK_EN && (ptr_nxt == LAST_PTR);
        if (index_q == LAST_IDX) begin
          index_q  <= '0;
          neuron_q <= neuron_q + 3'd1;
        end else begin
          index_q  <= index_q + IDX_W'(1);
        end
      end
    end else if (abort || handshake) begin
      // Leaving STREAM (abort, or handshake on the final word).
      last_q <= 1'b0;
    end
  end

  // --- Outputs ----------------------------------------------------------------
  assign stream.dump_data   = data_q;
  assign stream.dump_valid  = (state_q == STREAM);
  assign stream.dump_last   = last_q;
  assign stream.dump_neuron = neuron_q;
  assign stream.dump_index  = index_q;
  assign busy               = (state_q != IDLE);
  assign done               = (state_q == DONE);

endmodule
